// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the scrolling-text feeder of the 8x8 LED matrix.
package led_matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHAR,
        ST_GAP,
        ST_TAIL
    } scroll_state_e;

    localparam int unsigned MATRIX_DIM = 8;
    localparam int unsigned FRAME_W    = MATRIX_DIM * MATRIX_DIM;
    localparam logic [7:0]  BLANK_COL  = 8'h00;

endpackage

// File: rtl/led_step_prescaler.sv
// Free-running step divider: tick pulses every STEP_DIV enabled cycles, counter
// held at zero while disabled so each enable starts a fresh full period.
module led_step_prescaler #(
    parameter int unsigned STEP_DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned   CW   = $clog2(STEP_DIV);
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_matrix_scroller.sv
// Character buffer plus column-shifting frame builder that scrolls a text message
// across the 8x8 matrix driver; glyphs come from an external combinational decoder.
module led_matrix_scroller
    import led_matrix_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned STEP_DIV = 1000000,
    parameter int unsigned GAP      = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       wr_ready,
    input  logic                       clear,
    input  logic                       run,
    output logic [7:0]                 code_out,
    input  logic [FRAME_W-1:0]         glyph_in,
    output logic [FRAME_W-1:0]         array,
    output logic                       step,
    output logic [$clog2(DEPTH+1)-1:0] len
);

    localparam int unsigned LW       = $clog2(DEPTH + 1);
    localparam int unsigned IW       = $clog2(DEPTH);
    localparam logic [2:0]  LAST_COL = 3'(MATRIX_DIM - 1);
    localparam logic [2:0]  GAP_LAST = 3'((GAP == 0) ? 0 : GAP - 1);

    scroll_state_e      state_q, state_d;
    logic [LW-1:0]      len_q, len_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [2:0]         col_q, col_d;
    logic [2:0]         gap_q, gap_d;
    logic [FRAME_W-1:0] array_q, array_d;
    logic [7:0]         buf_q [DEPTH];
    logic [7:0]         new_col;
    logic               tick;
    logic               wr_fire;
    logic               advance;

    led_step_prescaler #(
        .STEP_DIV(STEP_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (run && (state_q != ST_IDLE)),
        .tick(tick)
    );

    assign wr_ready = (state_q == ST_IDLE) && (len_q < LW'(DEPTH));
    assign wr_fire  = wr_en && wr_ready && !clear;
    assign code_out = buf_q[idx_q];
    assign array    = array_q;
    assign len      = len_q;
    assign step     = tick;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        col_d   = col_q;
        gap_d   = gap_q;
        array_d = array_q;
        new_col = BLANK_COL;
        advance = 1'b0;

        if (state_q == ST_IDLE) begin
            array_d = '0;
            if (clear) begin
                len_d = '0;
            end else if (wr_fire) begin
                len_d = len_q + LW'(1);
            end
            if (run && (len_q != '0)) begin
                state_d = ST_CHAR;
                idx_d   = '0;
                col_d   = '0;
                gap_d   = '0;
            end
        end else if (!run) begin
            // Dropping run wins over a coincident tick: that column is discarded.
            state_d = ST_IDLE;
            array_d = '0;
            idx_d   = '0;
            col_d   = '0;
            gap_d   = '0;
        end else if (tick) begin
            case (state_q)
                ST_CHAR: begin
                    for (int unsigned r = 0; r < MATRIX_DIM; r++) begin
                        new_col[r] = glyph_in[r*MATRIX_DIM + int'(col_q)];
                    end
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (GAP > 0) begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        advance = 1'b1;
                    end else begin
                        gap_d = gap_q + 3'd1;
                    end
                end
                ST_TAIL: begin
                    // col doubles as the blank-column counter while flushing the screen.
                    if (col_q == LAST_COL) begin
                        col_d   = '0;
                        idx_d   = '0;
                        state_d = ST_CHAR;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
                default: ;
            endcase

            if (advance) begin
                if (idx_q == IW'(len_q - LW'(1))) begin
                    state_d = ST_TAIL;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = ST_CHAR;
                end
            end

            for (int unsigned r = 0; r < MATRIX_DIM; r++) begin
                for (int unsigned c = 0; c < MATRIX_DIM - 1; c++) begin
                    array_d[r*MATRIX_DIM + c] = array_q[r*MATRIX_DIM + c + 1];
                end
                array_d[r*MATRIX_DIM + MATRIX_DIM - 1] = new_col[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            col_q   <= '0;
            gap_q   <= '0;
            array_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            gap_q   <= gap_d;
            array_q <= array_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            buf_q[len_q[IW-1:0]] <= wr_data;
        end
    end

endmodule

// File: doc/led_matrix_scroller.md
Name: led_matrix_scroller

Overview:
- Upstream feeder for the 8x8 LED matrix driver: replaces a static glyph with a horizontally scrolling text message.
- Holds a buffer of up to DEPTH character codes and presents the current code to an external character decoder.
- Reads back that decoder's 64-bit glyph and shifts glyph columns into a 64-bit frame, one column per step tick.
- The frame feeds the driver's `array` input directly, in the same index layout: bit 8*row+col, col 0 leftmost, high = lit.

Parameters:
- DEPTH, 16: character buffer capacity (>=2).
- STEP_DIV, 1000000: clk cycles per one-column scroll step (>=2).
- GAP, 1: blank columns inserted after every character (0..7).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  append wr_data to the buffer.
- wr_data  in  8  character code to append.
- wr_ready  out  1  high when state==IDLE and len<DEPTH.
- clear  in  1  empty the buffer; honoured only in IDLE.
- run  in  1  level; scroll while high.
- code_out  out  8  buffer[char_idx], combinational; drives the decoder input.
- glyph_in  in  64  decoder output for code_out.
- array  out  64  current frame to the matrix driver.
- step  out  1  one-cycle pulse on every column shift.
- len  out  $clog2(DEPTH+1)  number of stored characters.

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE; len=0; char_idx=0; col=0; gap_cnt=0; prescaler=0.
  - array=0; step=0; wr_ready=1 after reset release.
- Write:
  - On wr_en & wr_ready, buffer[len] <= wr_data and len++.
  - wr_en when wr_ready=0 is ignored; len and buffer are unchanged.
- Clear: clear in IDLE sets len=0, buffer contents don't-care. clear has priority over wr_en in the same cycle. clear outside IDLE is ignored.
- Prescaler:
  - Counts only when state!=IDLE and resets to 0 on entry to CHAR from IDLE.
  - tick = (prescaler==STEP_DIV-1), then wraps to 0.
  - The first shift occurs exactly STEP_DIV cycles after the IDLE->CHAR transition clock edge.
- Shift operation on tick, for every row r:
  - array[8r+c] <= array[8r+c+1] for c=0..6.
  - array[8r+7] <= new_col[r].
  - step=1 for that cycle.
- State machine:
  - IDLE: array held at 0. If run & len>0, go to CHAR with char_idx=0, col=0.
  - CHAR: on tick, new_col[r] = glyph_in[8r+col], then col++. After col==7 shifts: col=0; if GAP>0 go to GAP, else advance.
  - GAP: on tick, new_col=0. After GAP shifts, advance.
  - Advance: if char_idx==len-1, go to TAIL; else char_idx++ and go to CHAR.
  - TAIL: on tick, new_col=0. After 8 shifts (screen blank), char_idx=0 and go to CHAR. The message loops indefinitely.
- run=0 in any non-IDLE state: next clock returns to IDLE, array<=0, prescaler/col/char_idx cleared. Same-cycle tick is discarded.
- glyph_in is sampled only on tick cycles. The decoder is combinational and code_out is stable between ticks, so one cycle of settle is guaranteed.
- len is frozen outside IDLE, so char_idx<len always holds.
- Reset asserted mid-scroll: immediate return to reset values, buffer is not preserved (len=0).

Decomposition:
- Shared package led_matrix_pkg:
  - state enum (IDLE, CHAR, GAP, TAIL).
  - MATRIX_DIM=8.
  - FRAME_W=64.
  - BLANK_COL=8'h00.
- One natural sub-module: led_step_prescaler.
  - Ports: clk, rst, en, tick.
  - Parameter: STEP_DIV.
  - Counter clears whenever en=0.

Test Plan (STEP_DIV=4, GAP=1, DEPTH=4, bench decoder model: code 8'd0 -> 64'h0018242424241800, all other codes -> 0):
1. Reset, write 8'd0, assert run -> first step pulse exactly 4 cycles after IDLE->CHAR. After 4 steps, array==64'h0080404040408000.
2. Continue scrolling the 1-character message -> step count per loop = 8+GAP+8 = 17. After TAIL, code_out==8'd0 and the pattern of scenario 1 recurs 17 steps later.
3. Write 4 codes, then a 5th -> wr_ready==0 after the 4th write, len==4, 5th write ignored. Assert run -> wr_ready==0 and clear ignored while scrolling.
4. Deassert run on the same cycle as a step tick -> next cycle state IDLE, array==0, no step pulse. Reassert run -> restart from char 0, col 0.
5. Assert rst low mid-GAP, asynchronously between clock edges -> array==0, len==0, step==0 immediately, before any clock edge.
6. clear and wr_en together in IDLE with len==3 -> len==0 and the write is dropped. Assert run with len==0 -> state stays IDLE.
